cache_arbiter: RTL and testbench
================================

# cache_arbiter

Shares the single physical-memory (cacheline adaptor) port between the instruction cache and the data cache in the mp4 pipeline. Grants one requester at a time, holds the grant for a full line transfer, and routes the response back to the owner. On a same-cycle conflict, it alternates round-robin so neither cache starves. It sits between the two cache controllers and the `pmem_*` burst port on the mp4 top level.

## Interface
- `ADDR_W`, 32, address width.
- `LINE_W`, 256, cache-line width in bits.
- `CNT_W`, 32, width of the conflict counter.

- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-low.
- `i_read` in 1: icache line-fill request.
- `i_address` in ADDR_W: icache line address.
- `i_rdata` out LINE_W: fill data to icache.
- `i_resp` out 1: icache transfer done.
- `d_read` in 1: dcache line-fill request.
- `d_write` in 1: dcache writeback request.
- `d_address` in ADDR_W: dcache line address.
- `d_wdata` in LINE_W: writeback data.
- `d_rdata` out LINE_W: fill data to dcache.
- `d_resp` out 1: dcache transfer done.
- `pmem_read` out 1: read strobe to the adaptor.
- `pmem_write` out 1: write strobe to the adaptor.
- `pmem_address` out ADDR_W: address to the adaptor.
- `pmem_wdata` out LINE_W: write line to the adaptor.
- `pmem_rdata` in LINE_W: read line from the adaptor.
- `pmem_resp` in 1: adaptor transfer complete.
- `conflict_cnt` out CNT_W: count of IDLE cycles in which both caches requested.

## Operation
- **States:** IDLE, I_BUSY, D_BUSY.
- **IDLE, no request:** remain in IDLE.
- **IDLE, one requester:** grant it.
- **IDLE, both requesting:** grant the cache that is not `last_grant`.
  - `last_grant` resets to ICACHE, so the first conflict goes to dcache.
  - `conflict_cnt` increments, saturating at all-ones.
- **On grant:** register into `req_addr`, `req_wdata` and `req_is_write`:
  - the address,
  - `d_wdata` (dcache grant only),
  - `d_write` (dcache grant only).
  - Then go to I_BUSY or D_BUSY and update `last_grant`.
- **Owner must hold its request until its resp.** Address and data changes after the grant are ignored.
- **BUSY outputs:**
  - `pmem_address` = `req_addr`.
  - `pmem_read` = !`req_is_write`.
  - `pmem_write` = `req_is_write`.
  - `pmem_wdata` = `req_wdata`.
  - All pmem outputs are registered or state-decoded, with no combinational path from cache inputs.
- **BUSY and `pmem_resp` = 1:**
  - The owner's `x_resp` = 1 in the same cycle.
  - The owner's `x_rdata` = `pmem_rdata` (combinational pass-through).
  - Next state is IDLE.
- **Non-owner** sees `x_resp` = 0 and `x_rdata` = 0 at all times.
- **`d_read` and `d_write` both high** is illegal. `d_write` wins and a simulation assertion fires.
- **`pmem_resp` in IDLE** is ignored; an assertion fires.
- **Reset (`rst` = 0 at a clock edge):**
  - state = IDLE and `last_grant` = ICACHE;
  - `req_*` = 0 and `conflict_cnt` = 0;
  - `pmem_read`, `pmem_write`, `i_resp` and `d_resp` = 0.
- **Reset mid-transfer** abandons the transfer. The adaptor is reset by the same `rst`.

## Timing
- **Grant latency:** a request sampled in IDLE at edge t produces a `pmem_*` strobe in cycle t+1.
- **Response latency:** `x_resp` is asserted in the same cycle as `pmem_resp`, for exactly one cycle.
- **Turnaround:**
  - `pmem_resp` in cycle k is followed by IDLE in cycle k+1.
  - The next strobe is earliest in cycle k+2, giving one dead cycle between transfers.
- **Back-to-back conflict:** the cache waiting through the IDLE cycle k+1 receives the next grant. Round-robin guarantees each cache waits at most one other transfer.
- **Strobe shape:** strobes remain level-high for the whole BUSY state; they are not pulses.

## Structure
- Package `arbiter_types` (shared):
  - `arb_state_t` (IDLE, I_BUSY, D_BUSY);
  - `arb_owner_t` (ICACHE, DCACHE);
  - the `LINE_W` and `ADDR_W` defaults.
- A single module with an FSM, request latch and saturating counter; no sub-module is needed.
- It is instantiated in the `mp4` top between `icache`/`dcache` and `cacheline_adaptor`.

## Test plan
- **Single icache fill:** `i_read` = 1, `i_address` = 0x60, and the model gives `pmem_resp` 10 cycles later with data 0xA5..A5 → `pmem_read` rises one cycle after the request, `pmem_address` = 0x60, `i_resp` is a one-cycle pulse with `i_rdata` = 0xA5..A5, and `d_resp` stays 0.
- **Dcache writeback:** `d_write` = 1, `d_address` = 0x100, `d_wdata` = 0x1234.. → `pmem_write` = 1 and `pmem_read` = 0 throughout. The latched `pmem_wdata` is unchanged even when `d_wdata` is altered after the grant.
- **Simultaneous requests from reset:** → dcache is served first and `conflict_cnt` = 1. The icache strobe begins exactly 2 cycles after the dcache `pmem_resp`.
- **Sustained contention:** 6 back-to-back conflicting transfers → grants alternate D, I, D, I, D, I with no starvation.
- **Reset mid-transfer:** assert `rst` = 0 in the 3rd BUSY cycle → the next cycle shows all strobes 0, state IDLE and `conflict_cnt` = 0. A fresh `i_read` after release is granted normally.
- **Counter saturation:** with `CNT_W` = 2, force 5 conflicts → `conflict_cnt` holds at 3.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache-to-memory arbiter: FSM state, grant owner and
// the default address/line widths used by the mp4 memory hierarchy.
// Pure declarations; no logic, no latency, no flow control.
package arbiter_types;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned LINE_W_DEF = 256;

  // Arbiter FSM: either idle or holding a grant for one cache until the
  // adaptor signals the end of the line transfer.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

  // Which cache received the most recent grant; drives round-robin.
  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/cache_arbiter.sv
// Purpose: shares the single pmem (cacheline adaptor) port between icache and
//   dcache, holding each grant for a whole line and routing the response back.
// Latency: request seen in IDLE at edge t -> pmem strobe in cycle t+1;
//   x_resp is combinational with pmem_resp; one dead IDLE cycle per transfer.
// Backpressure: a cache that is not granted simply keeps its request high;
//   round-robin on conflicts bounds its wait to one foreign transfer.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   i_read/i_address         icache fill request; i_rdata/i_resp back
//   d_read/d_write/d_address dcache fill or writeback request; d_wdata line
//   d_rdata/d_resp           dcache fill data and completion
//   pmem_read/pmem_write     level strobes for the whole BUSY state
//   pmem_address/pmem_wdata  latched request towards the adaptor
//   pmem_rdata/pmem_resp     adaptor read line and completion pulse
//   conflict_cnt             saturating count of IDLE cycles with both requests
module cache_arbiter
  import arbiter_types::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,

  output logic [CNT_W-1:0]  conflict_cnt
);

  arb_state_t        state_q,        state_d;
  arb_owner_t        last_grant_q,   last_grant_d;
  logic [ADDR_W-1:0] req_addr_q,     req_addr_d;
  logic [LINE_W-1:0] req_wdata_q,    req_wdata_d;
  logic              req_is_write_q, req_is_write_d;
  logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

  logic d_req;
  logic both_req;
  logic grant_d_side;

  // A writeback is a dcache request just like a fill; if both strobes are
  // (illegally) high, d_write decides the direction below.
  assign d_req    = d_read | d_write;
  assign both_req = i_read & d_req;

  // Dcache wins when it is alone, or on a conflict when icache was served
  // last. Since last_grant resets to ICACHE, the first conflict goes to dcache.
  assign grant_d_side = d_req & (~i_read | (last_grant_q == ICACHE));

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    req_addr_d     = req_addr_q;
    req_wdata_d    = req_wdata_q;
    req_is_write_d = req_is_write_q;
    conflict_cnt_d = conflict_cnt_q;

    case (state_q)
      IDLE: begin
        if (grant_d_side) begin
          state_d        = D_BUSY;
          last_grant_d   = DCACHE;
          req_addr_d     = d_address;
          req_wdata_d    = d_wdata;
          req_is_write_d = d_write;
        end else if (i_read) begin
          state_d        = I_BUSY;
          last_grant_d   = ICACHE;
          req_addr_d     = i_address;
          req_wdata_d    = '0;
          req_is_write_d = 1'b0;
        end

        // Conflicts are only counted where arbitration actually happens.
        if (both_req && !(&conflict_cnt_q)) begin
          conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
      end

      I_BUSY, D_BUSY: begin
        // Latched request stays put until the adaptor completes; any change
        // on the cache-side address/data meanwhile is ignored.
        if (pmem_resp) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      last_grant_q   <= ICACHE;
      req_addr_q     <= '0;
      req_wdata_q    <= '0;
      req_is_write_q <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      req_addr_q     <= req_addr_d;
      req_wdata_q    <= req_wdata_d;
      req_is_write_q <= req_is_write_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  logic busy;
  logic i_owner;
  logic d_owner;

  assign busy    = (state_q != IDLE);
  assign i_owner = (state_q == I_BUSY);
  assign d_owner = (state_q == D_BUSY);

  // pmem side is driven only from registers and the decoded state, so no
  // cache input can reach the adaptor combinationally.
  assign pmem_read    = busy & ~req_is_write_q;
  assign pmem_write   = busy &  req_is_write_q;
  assign pmem_address = req_addr_q;
  assign pmem_wdata   = req_wdata_q;

  // Response path is a pure pass-through gated by ownership, so the
  // non-owner never sees data or a completion.
  assign i_resp  = i_owner & pmem_resp;
  assign d_resp  = d_owner & pmem_resp;
  assign i_rdata = i_owner ? pmem_rdata : '0;
  assign d_rdata = d_owner ? pmem_rdata : '0;

  assign conflict_cnt = conflict_cnt_q;

`ifndef SYNTHESIS
  // A dcache asking to read and write the same line at once is a controller
  // bug; the write still takes priority in hardware.
  a_d_read_write_excl : assert property (
    @(posedge clk) disable iff (!rst) !(d_read && d_write)
  );

  // The adaptor must never complete a transfer nobody owns.
  a_no_resp_in_idle : assert property (
    @(posedge clk) disable iff (!rst) (state_q == IDLE) |-> !pmem_resp
  );
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

  logic          clk;
  logic          rst;
  logic          i_read;
  logic [31:0]   i_address;
  logic [255:0]  i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [31:0]   d_address;
  logic [255:0]  d_wdata;
  logic [255:0]  d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [31:0]   pmem_address;
  logic [255:0]  pmem_wdata;
  logic [255:0]  pmem_rdata;
  logic          pmem_resp;
  logic [31:0]   conflict_cnt;

  // Narrow-counter instance sharing the same stimulus, for saturation.
  logic [255:0]  s_i_rdata, s_d_rdata, s_pmem_wdata;
  logic          s_i_resp, s_d_resp, s_pmem_read, s_pmem_write;
  logic [31:0]   s_pmem_address;
  logic [1:0]    s_conflict_cnt;

  cache_arbiter #(.ADDR_W(32), .LINE_W(256), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .conflict_cnt(conflict_cnt)
  );

  cache_arbiter #(.ADDR_W(32), .LINE_W(256), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(s_i_rdata), .i_resp(s_i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(s_d_rdata), .d_resp(s_d_resp),
    .pmem_read(s_pmem_read), .pmem_write(s_pmem_write), .pmem_address(s_pmem_address),
    .pmem_wdata(s_pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .conflict_cnt(s_conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } ptx_t;

  typedef struct {
    logic         ir;
    logic         dr;
    logic [255:0] ird;
    logic [255:0] drd;
  } rsp_t;

  ptx_t exp_p[$];
  rsp_t exp_r[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int mem_lat = 10;
  int busy_cnt = 0;
  int last_resp_cyc = -1000;
  int last_gap = 0;
  bit mon_en = 1'b0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory contents seen through the adaptor.
  function automatic logic [255:0] model_data(input logic [31:0] a);
    logic [255:0] r;
    r = {8{a ^ 32'hC3C3_0000}};
    if (a == 32'h60) r = {32{8'hA5}};
    return r;
  endfunction

  task automatic push_txn(input bit is_d, input bit wr, input logic [31:0] a, input logic [255:0] wd);
    ptx_t p;
    rsp_t r;
    p.wr = wr; p.addr = a; p.wdata = wd;
    r.ir = !is_d; r.dr = is_d;
    r.ird = is_d ? 256'h0 : model_data(a);
    r.drd = is_d ? model_data(a) : 256'h0;
    exp_p.push_back(p);
    exp_r.push_back(r);
  endtask

  task automatic wait_resp(input bit is_d, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_d ? d_resp : i_resp) && n < 300);
    check({nm, " resp before timeout"}, 256'(n < 300), 256'(1));
  endtask

  task automatic icache_req(input logic [31:0] a);
    i_read = 1'b1;
    i_address = a;
    wait_resp(1'b0, "icache");
    @(posedge clk); #1;
    i_read = 1'b0;
  endtask

  task automatic dcache_req(input logic [31:0] a, input bit wr, input logic [255:0] wd);
    d_read = !wr;
    d_write = wr;
    d_address = a;
    d_wdata = wd;
    wait_resp(1'b1, "dcache");
    @(posedge clk); #1;
    d_read = 1'b0;
    d_write = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Adaptor model: completes after mem_lat strobe cycles.
  initial begin
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (!rst || pmem_resp) begin
        pmem_resp = 1'b0;
        busy_cnt = 0;
      end else if (pmem_read || pmem_write) begin
        busy_cnt++;
        if (busy_cnt == mem_lat) begin
          pmem_resp = 1'b1;
          pmem_rdata = model_data(pmem_address);
        end
      end else begin
        busy_cnt = 0;
      end
    end
  end

  // Monitor: pops expected transfers/responses when the DUT presents them.
  initial begin : monitor
    ptx_t cur;
    rsp_t r;
    logic prev_strobe;
    logic strobe;
    prev_strobe = 1'b0;
    cur.wr = 1'b0; cur.addr = '0; cur.wdata = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        strobe = pmem_read | pmem_write;
        if (strobe && !prev_strobe) begin
          last_gap = cyc - last_resp_cyc;
          check("grant was expected", 256'(exp_p.size() != 0), 256'(1));
          if (exp_p.size() != 0) cur = exp_p.pop_front();
        end
        if (strobe) begin
          check("pmem read/write strobes", 256'({pmem_read, pmem_write}), 256'({!cur.wr, cur.wr}));
          check("pmem_address", 256'(pmem_address), 256'(cur.addr));
          check("pmem_wdata", pmem_wdata, cur.wdata);
        end else begin
          check("idle resp quiet", 256'({i_resp, d_resp}), 256'(0));
          check("idle rdata quiet", i_rdata | d_rdata, 256'(0));
        end
        if (i_resp || d_resp) begin
          last_resp_cyc = cyc;
          check("response was expected", 256'(exp_r.size() != 0), 256'(1));
          if (exp_r.size() != 0) begin
            r = exp_r.pop_front();
            check("resp flags", 256'({i_resp, d_resp}), 256'({r.ir, r.dr}));
            check("i_rdata", i_rdata, r.ird);
            check("d_rdata", d_rdata, r.drd);
          end
        end
        prev_strobe = strobe;
      end
    end
  end

  initial begin : watchdog
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [255:0] wd;
    rst = 1'b0;
    i_read = 0; i_address = '0;
    d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset pmem_read", 256'(pmem_read), 256'(0));
    check("reset pmem_write", 256'(pmem_write), 256'(0));
    check("reset resp", 256'({i_resp, d_resp}), 256'(0));
    check("reset conflict_cnt", 256'(conflict_cnt), 256'(0));
    check("reset pmem_address", 256'(pmem_address), 256'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Single icache fill, 10-cycle adaptor.
    mem_lat = 10;
    push_txn(1'b0, 1'b0, 32'h60, 256'h0);
    i_read = 1'b1; i_address = 32'h60;
    @(negedge clk);
    check("strobe not yet in request cycle", 256'(pmem_read), 256'(0));
    @(negedge clk);
    check("pmem_read one cycle after request", 256'(pmem_read), 256'(1));
    check("fill address", 256'(pmem_address), 256'(32'h60));
    wait_resp(1'b0, "single fill");
    @(posedge clk); #1;
    i_read = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Dcache writeback; data/address changes after grant are ignored.
    mem_lat = 6;
    wd = {8{32'h1234_5678}};
    push_txn(1'b1, 1'b1, 32'h100, wd);
    d_write = 1'b1; d_address = 32'h100; d_wdata = wd;
    @(posedge clk); #1;
    @(posedge clk); #1;
    d_wdata = ~wd;
    d_address = 32'h999;
    wait_resp(1'b1, "writeback");
    @(posedge clk); #1;
    d_write = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Simultaneous requests right after reset: dcache first.
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    mem_lat = 4;
    push_txn(1'b1, 1'b0, 32'h300, 256'h0);
    push_txn(1'b0, 1'b0, 32'h200, 256'h0);
    fork
      icache_req(32'h200);
      dcache_req(32'h300, 1'b0, 256'h0);
    join
    check("turnaround gap", 256'(last_gap), 256'(2));
    check("conflict_cnt after first conflict", 256'(conflict_cnt), 256'(1));
    check("narrow conflict_cnt after first conflict", 256'(s_conflict_cnt), 256'(1));

    // Sustained contention: D, I, D, I, D, I.
    push_txn(1'b1, 1'b0, 32'h1000, 256'h0);
    push_txn(1'b0, 1'b0, 32'h2000, 256'h0);
    push_txn(1'b1, 1'b0, 32'h1040, 256'h0);
    push_txn(1'b0, 1'b0, 32'h2040, 256'h0);
    push_txn(1'b1, 1'b0, 32'h1080, 256'h0);
    push_txn(1'b0, 1'b0, 32'h2080, 256'h0);
    fork
      begin
        icache_req(32'h2000);
        icache_req(32'h2040);
        icache_req(32'h2080);
      end
      begin
        dcache_req(32'h1000, 1'b0, 256'h0);
        dcache_req(32'h1040, 1'b0, 256'h0);
        dcache_req(32'h1080, 1'b0, 256'h0);
      end
    join
    check("conflict_cnt after contention", 256'(conflict_cnt), 256'(6));
    check("narrow conflict_cnt saturated", 256'(s_conflict_cnt), 256'(3));
    repeat (2) @(posedge clk); #1;

    // Reset in the third BUSY cycle abandons the transfer.
    mem_lat = 10;
    exp_p.push_back('{wr: 1'b0, addr: 32'h400, wdata: 256'h0});
    i_read = 1'b1; i_address = 32'h400;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    i_read = 1'b0;
    @(posedge clk); #1;
    check("abort pmem strobes", 256'({pmem_read, pmem_write}), 256'(0));
    check("abort resp", 256'({i_resp, d_resp}), 256'(0));
    check("abort conflict_cnt", 256'(conflict_cnt), 256'(0));
    check("abort narrow conflict_cnt", 256'(s_conflict_cnt), 256'(0));
    check("abort pmem_address", 256'(pmem_address), 256'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    mem_lat = 4;
    push_txn(1'b0, 1'b0, 32'h440, 256'h0);
    icache_req(32'h440);
    check("conflict_cnt after abort", 256'(conflict_cnt), 256'(0));

    repeat (3) @(negedge clk);
    check("pending grants drained", 256'(exp_p.size()), 256'(0));
    check("pending responses drained", 256'(exp_r.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
